// File: rtl/csel_subtractor_seq.sv
// -----------------------------------------------------------------------------
// csel_subtractor_seq
//
// Sequential carry-select subtractor: diff = a - b - bin (mod 2^WIDTH),
// one CHUNK-bit slice per clock, least significant slice first. Each slice
// computes both borrow-in candidates side by side; the borrow registered by
// the previous slice picks one, so no borrow ripples across slices within a
// cycle.
//
// Optional feature: define CSEL_SUB_OVF_EN to compute the signed overflow flag.
// Without it, ovf is tied to 0 and no overflow logic exists.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, highest priority
//   in_valid   operands valid          in_ready   block accepts operands (IDLE)
//   a, b, bin  minuend, subtrahend, borrow in (latched on accept)
//   out_valid  result valid (DONE)     out_ready  consumer takes result
//   diff       a - b - bin             bout       1 iff a < b + bin (unsigned)
//   ovf        signed overflow (0 unless CSEL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module csel_subtractor_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [IW-1:0]    idx_q;
   logic             borrow_q;
   logic             bout_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // Current slice operands and both borrow-in candidates. The extra top bit
   // of each difference is the slice borrow-out (set when the result went
   // negative).
   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK:0]   sub0;
   logic [CHUNK:0]   sub1;
   logic [CHUNK-1:0] r_sel_d;
   logic             b_sel_d;

   always_comb begin
      a_slice = a_q[idx_q*CHUNK +: CHUNK];
      b_slice = b_q[idx_q*CHUNK +: CHUNK];
      sub0    = {1'b0, a_slice} - {1'b0, b_slice};
      sub1    = {1'b0, a_slice} - {1'b0, b_slice} - (CHUNK+1)'(1);
      r_sel_d = borrow_q ? sub1[CHUNK-1:0] : sub0[CHUNK-1:0];
      b_sel_d = borrow_q ? sub1[CHUNK]     : sub0[CHUNK];
   end

`ifdef CSEL_SUB_OVF_EN
   logic ovf_q;
   // Overflow when operand signs differ and the result sign differs from a.
   // On the last slice the top bit of r_sel_d is the result MSB.
   logic ovf_d;
   assign ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_sel_d[CHUNK-1] != a_q[WIDTH-1]);
   assign ovf   = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         idx_q       <= '0;
         borrow_q    <= 1'b0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  borrow_q   <= bin;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               diff_q[idx_q*CHUNK +: CHUNK] <= r_sel_d;
               borrow_q <= b_sel_d;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  bout_q      <= b_sel_d;
`ifdef CSEL_SUB_OVF_EN
                  ovf_q       <= ovf_d;
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               // Results stay frozen until taken; new operands are not
               // accepted in this cycle, only once back in IDLE.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_csel_subtractor_seq.sv
// -----------------------------------------------------------------------------
// tb_csel_subtractor_seq
//
// Self-checking bench for csel_subtractor_seq (WIDTH=8, CHUNK=4). Expected
// results come from a plain-arithmetic reference model and are queued when
// operands are accepted; a monitor pops and compares on every result
// handshake. Directed phases also check latency, backpressure and reset.
// Define CSEL_SUB_OVF_EN for both bench and design to exercise ovf.
// -----------------------------------------------------------------------------
module tb_csel_subtractor_seq;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   csel_subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             bo;
      logic             ov;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: unsigned and signed integer arithmetic on whole operands.
   function automatic exp_t model(input int ai, input int bi, input int ci);
      exp_t e;
      int   r;
      int   sa;
      int   sb;
      int   sr;
      r    = ai - bi - ci;
      e.d  = WIDTH'(r);
      e.bo = (ai < bi + ci);
      sa   = (ai >= 128) ? ai - 256 : ai;
      sb   = (bi >= 128) ? bi - 256 : bi;
      sr   = sa - sb - ci;
`ifdef CSEL_SUB_OVF_EN
      e.ov = (sr < -128) || (sr > 127);
`else
      e.ov = 1'b0;
      if (sr == 0) e.ov = 1'b0;
`endif
      return e;
   endfunction

   // Monitor: a result is consumed at the next rising edge when out_valid and
   // out_ready are both high; values are stable at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(diff), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               $display("result: diff=0x%02h bout=%0b ovf=%0b (expected 0x%02h %0b %0b)",
                        diff, bout, ovf, e.d, e.bo, e.ov);
               chk("diff", 32'(diff), 32'(e.d));
               chk("bout", 32'(bout), 32'(e.bo));
               chk("ovf",  32'(ovf),  32'(e.ov));
            end
         end
      end
   end

   // Present operands until accepted; returns just after the accept edge.
   task automatic send(input int ai, input int bi, input int ci, input bit push);
      int w;
      a = WIDTH'(ai); b = WIDTH'(bi); bin = ci[0];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 50) chk("accept_timeout", 32'(w), 32'(0));
      if (push) exp_q.push_back(model(ai, bi, ci));
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Operands may change freely once accepted.
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
   endtask

   task automatic wait_valid();
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         @(posedge clk); #1; cnt++;
      end
      chk("latency", 32'(cnt), 32'(NCHUNK));
   endtask

   task automatic run_op(input int ai, input int bi, input int ci, input bit rand_bp);
      int  cyc;
      bit  done;
      send(ai, bi, ci, 1'b1);
      wait_valid();
      done = 1'b0;
      for (cyc = 0; cyc < 40 && !done; cyc++) begin
         out_ready = (!rand_bp || cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) chk("handshake_timeout", 32'(cyc), 32'(0));
      out_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_diff",      32'(diff),      32'(0));
      chk("rst_bout",      32'(bout),      32'(0));
      chk("rst_ovf",       32'(ovf),       32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases, including inter-slice borrow selection and wrap.
      run_op(8'h06, 8'h06, 0, 1'b0);
      run_op(8'h0E, 8'h07, 0, 1'b0);
      run_op(8'h02, 8'h09, 0, 1'b0);
      run_op(8'h00, 8'h00, 1, 1'b0);
      run_op(8'h80, 8'h01, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 1, 1'b0);
      run_op(8'h7F, 8'hFF, 0, 1'b0);

      // Backpressure: outputs frozen, in_valid ignored.
      out_ready = 1'b0;
      send(8'h35, 8'h12, 0, 1'b1);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'(1));
         chk("bp_diff",      32'(diff),      32'h23);
         chk("bp_bout",      32'(bout),      32'(0));
         chk("bp_in_ready",  32'(in_ready),  32'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready",  32'(in_ready),  32'(1));
      chk("bp_release_out_valid", 32'(out_valid), 32'(0));
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_no_spurious", 32'(out_valid), 32'(0));
      end

      // Reset in the first RUN cycle discards the operation.
      send(8'hFF, 8'h01, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_in_ready",  32'(in_ready),  32'(1));
      chk("midrst_diff",      32'(diff),      32'(0));
      chk("midrst_bout",      32'(bout),      32'(0));
      run_op(8'h10, 8'h01, 0, 1'b0);

      // Randomized operations with idle gaps and random backpressure.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), 1'b1);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
